// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and width helpers for the fetch->decode instruction queue.
package fetch_inst_queue_pkg;

  localparam int FIQ_XLEN = 32;

  typedef struct packed {
    logic [FIQ_XLEN-1:0] inst;
    logic [FIQ_XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int FIQ_ENTRY_W = $bits(fetch_entry_t);

  // Counter width able to hold the value n itself (0..n inclusive).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int FIQ_CNT_W = cnt_w(4);

endpackage

// File: rtl/fetch_ring_buf.sv
// DEPTH-entry ring buffer with plain push/pop strobes; the caller guarantees no overflow/underflow.
// Head data is read straight from registered storage, so a push is visible one cycle later.
module fetch_ring_buf
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIQ_ENTRY_W,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_dat_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_inst_queue.sv
// Credit-based fetch->decode queue: issues requests only when a slot is reserved for the response,
// and after a redirect drops the wrong-path responses still in flight.
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = FIQ_XLEN,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int OC_W  = cnt_w(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_miss,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             rsp_valid,
  input  logic [XLEN-1:0]  rsp_inst,
  input  logic [XLEN-1:0]  rsp_pc,
  output logic             deq_valid,
  output logic [XLEN-1:0]  deq_inst,
  output logic [XLEN-1:0]  deq_pc,
  input  logic             deq_ready,
  output logic [CNT_W-1:0] count,
  output logic             proto_err
);

  localparam int SUM_W = ((CNT_W > OC_W) ? CNT_W : OC_W) + 1;

  logic [OC_W-1:0]   live_q, live_d;
  logic [OC_W-1:0]   stale_q, stale_d;
  logic              proto_err_q, proto_err_d;

  logic [SUM_W-1:0]  occ_sum, out_sum, flush_stale;
  logic              fire, pop, push;
  logic              rsp_stale, rsp_live, rsp_err;
  logic [2*XLEN-1:0] head_dat;

  // occ_sum counts held entries plus slots promised to live requests.
  assign occ_sum   = SUM_W'(count) + SUM_W'(live_q);
  assign out_sum   = SUM_W'(live_q) + SUM_W'(stale_q);
  assign req_ready = !pred_miss
                   && (occ_sum < SUM_W'(DEPTH))
                   && (out_sum < SUM_W'(MAX_OUTSTANDING));
  assign fire      = req_valid && req_ready;

  // In-order bus: stale responses always drain ahead of live ones.
  assign rsp_stale = rsp_valid && (stale_q != '0);
  assign rsp_live  = rsp_valid && (stale_q == '0) && (live_q != '0);
  assign rsp_err   = rsp_valid && (stale_q == '0) && (live_q == '0);

  assign push      = rsp_live && !pred_miss;
  assign deq_valid = (count != '0) && !pred_miss;
  assign pop       = deq_valid && deq_ready;

  // A flush converts every live request into a stale one, minus any that answers this cycle.
  assign flush_stale = SUM_W'(stale_q) + SUM_W'(live_q) + SUM_W'(fire)
                     - SUM_W'(rsp_valid && !rsp_err);

  always_comb begin
    live_d      = live_q;
    stale_d     = stale_q;
    proto_err_d = proto_err_q || rsp_err;
    if (pred_miss) begin
      live_d  = '0;
      stale_d = OC_W'(flush_stale);
    end else begin
      live_d  = live_q + OC_W'(fire) - OC_W'(rsp_live);
      stale_d = stale_q - OC_W'(rsp_stale);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= '0;
      stale_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      live_q      <= live_d;
      stale_q     <= stale_d;
      proto_err_q <= proto_err_d;
    end
  end

  fetch_ring_buf #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (pred_miss),
    .push_i     (push),
    .push_dat_i ({rsp_inst, rsp_pc}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign deq_inst  = head_dat[2*XLEN-1:XLEN];
  assign deq_pc    = head_dat[XLEN-1:0];
  assign proto_err = proto_err_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));
  a_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    out_sum <= SUM_W'(MAX_OUTSTANDING));
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    occ_sum <= SUM_W'(DEPTH));
  a_no_ready_flush: assert property (@(posedge clk) disable iff (!rst_n)
    pred_miss |-> !req_ready);

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: reset, fill/drain, streaming, flushes and protocol error.
module tb_fetch_inst_queue;
  import fetch_inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pred_miss, req_valid, req_ready, rsp_valid;
  logic [XLEN-1:0] rsp_inst, rsp_pc, deq_inst, deq_pc;
  logic            deq_valid, deq_ready, proto_err;
  logic [2:0]      count;

  int checks_n = 0;
  int errors_n = 0;

  always #5 clk = ~clk;

  fetch_inst_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pred_miss (pred_miss),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_inst  (rsp_inst),
    .rsp_pc    (rsp_pc),
    .deq_valid (deq_valid),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .deq_ready (deq_ready),
    .count     (count),
    .proto_err (proto_err)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0000_0013 ^ (pc << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    assert (obs === exp) else begin
      errors_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rsp(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc      = pc;
    e.inst    = inst_of(pc);
    rsp_valid = 1'b1;
    rsp_pc    = e.pc;
    rsp_inst  = e.inst;
  endtask

  initial begin
    rst_n = 1'b0; pred_miss = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;
    rsp_inst = '0; rsp_pc = '0; deq_ready = 1'b0;

    // Reset
    #12;
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_proto_err", proto_err, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Fill: four requests exhaust both credit pools
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fill_req_ready", req_ready, 1);
      tick();
    end
    #1 chk("fill_ready_low", req_ready, 0);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        chk("fill_lat_valid", deq_valid, 1);
        chk("fill_lat_pc", deq_pc, 0);
        chk("fill_lat_count", count, 1);
      end
      drive_rsp(32'(4*i));
      tick();
    end
    rsp_valid = 1'b0;
    #1;
    chk("fill_count4", count, 4);
    chk("fill_full_ready", req_ready, 0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", deq_pc, 32'(4*i));
      chk("drain_inst", deq_inst, inst_of(32'(4*i)));
      tick();
    end
    deq_ready = 1'b0;
    #1;
    chk("drain_count0", count, 0);
    chk("drain_deq_valid", deq_valid, 0);

    // Streaming: one request, one response and one pop per cycle
    deq_ready = 1'b1;
    req_valid = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 5);
      drive_rsp(32'h20 + 32'(4*k));
      #1;
      if (k > 0) begin
        chk("stream_valid", deq_valid, 1);
        chk("stream_pc", deq_pc, 32'h20 + 32'(4*(k-1)));
        chk("stream_count", count, 1);
      end
      tick();
    end
    rsp_valid = 1'b0; req_valid = 1'b0;
    #1 chk("stream_last_pc", deq_pc, 32'h34);
    tick();
    deq_ready = 1'b0;
    #1 chk("stream_empty", count, 0);

    // Flush with two queued and two live
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    req_valid = 1'b0;
    drive_rsp(32'h40); tick();
    drive_rsp(32'h44); tick();
    rsp_valid = 1'b0;
    #1 chk("flush_pre_count", count, 2);
    pred_miss = 1'b1; req_valid = 1'b1;
    #1;
    chk("flush_deq_valid", deq_valid, 0);
    chk("flush_req_ready", req_ready, 0);
    tick();
    pred_miss = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_post_valid", deq_valid, 0);
    chk("flush_stale", 32'(dut.stale_q), 2);
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    drive_rsp(32'hDEAD0); tick();
    rsp_valid = 1'b0;
    #1 chk("stale_drop1", count, 0);
    drive_rsp(32'hDEAD4); tick();
    rsp_valid = 1'b0;
    #1 chk("stale_drop2", count, 0);
    drive_rsp(32'h100); tick();
    rsp_valid = 1'b0;
    #1;
    chk("after_stale_count", count, 1);
    chk("after_stale_valid", deq_valid, 1);
    chk("after_stale_pc", deq_pc, 32'h100);
    chk("after_stale_err", proto_err, 0);
    deq_ready = 1'b1; tick(); deq_ready = 1'b0;

    // Flush coincident with the only live response
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    pred_miss = 1'b1;
    drive_rsp(32'h200);
    tick();
    pred_miss = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("coinc_count", count, 0);
    chk("coinc_stale", 32'(dut.stale_q), 0);
    chk("coinc_live", 32'(dut.live_q), 0);
    chk("coinc_err", proto_err, 0);
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    drive_rsp(32'h300); tick();
    rsp_valid = 1'b0;
    #1;
    chk("coinc_next_pc", deq_pc, 32'h300);
    chk("coinc_next_count", count, 1);

    // Protocol error: response with nothing outstanding
    drive_rsp(32'hBAD); tick();
    rsp_valid = 1'b0;
    #1;
    chk("perr_set", proto_err, 1);
    chk("perr_count", count, 1);
    chk("perr_head_pc", deq_pc, 32'h300);
    tick();
    chk("perr_sticky", proto_err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_err", proto_err, 0);
    chk("arst_count", count, 0);
    chk("arst_valid", deq_valid, 0);
    chk("arst_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_err", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
